// File: rtl/otter_lsu.sv
// otter_lsu: byte/half/word load-store unit driving the word-wide data memory port
module otter_lsu (
    input  logic        CLK,
    input  logic        RST,
    input  logic        LSU_REQ,
    input  logic        LSU_WE,
    input  logic [1:0]  LSU_SIZE,
    input  logic        LSU_SIGN,
    input  logic [31:0] LSU_ADDR,
    input  logic [31:0] LSU_WDATA,
    output logic        LSU_READY,
    output logic        LSU_DONE,
    output logic        LSU_ERR,
    output logic [31:0] LSU_RDATA,
    output logic        MEM_RDEN2,
    output logic        MEM_WE2,
    output logic [31:0] MEM_ADDR2,
    output logic [31:0] MEM_DIN2,
    input  logic [31:0] MEM_DOUT2
);
    typedef enum logic [2:0] {IDLE, RD, RMW_RD, WR, RESP} state_t;

    state_t      state, next;
    logic [1:0]  size;
    logic        sign;
    logic [31:0] addr, wdata, merge;
    logic        err;
    logic        misaligned;
    logic [4:0]  shift;
    logic [15:0] lane;
    logic [31:0] mask, load_val, merged;

    assign misaligned = (LSU_SIZE == 2'b01 && LSU_ADDR[0]) ||
                        (LSU_SIZE == 2'b10 && LSU_ADDR[1:0] != 2'b00) ||
                        LSU_SIZE == 2'b11;
    assign shift    = {addr[1:0], 3'b000};
    assign lane     = 16'(MEM_DOUT2 >> shift);
    assign load_val = size == 2'b00 ? {{24{sign & lane[7]}}, lane[7:0]} :
                      size == 2'b01 ? {{16{sign & lane[15]}}, lane} : MEM_DOUT2;
    assign mask     = (size == 2'b00 ? 32'h0000_00FF : 32'h0000_FFFF) << shift;
    assign merged   = (MEM_DOUT2 & ~mask) | ((wdata << shift) & mask);

    // state register
    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= next;
    end

    // next-state and memory/handshake outputs
    always_comb begin
        next      = state;
        LSU_READY = state == IDLE;
        LSU_DONE  = state == RESP;
        LSU_ERR   = state == RESP && err;
        MEM_RDEN2 = state == RD || state == RMW_RD;
        MEM_WE2   = state == WR && !RST;
        MEM_ADDR2 = (state == RD || state == RMW_RD || state == WR) ? {addr[31:2], 2'b00} : 32'h0;
        MEM_DIN2  = state == WR ? merge : 32'h0;
        case (state)
            IDLE:    if (LSU_REQ) next = misaligned ? RESP : !LSU_WE ? RD :
                                         LSU_SIZE == 2'b10 ? WR : RMW_RD;
            RD:      next = RESP;
            RMW_RD:  next = WR;
            WR:      next = RESP;
            RESP:    next = IDLE;
            default: next = IDLE;
        endcase
    end

    // request capture, load result and store merge word
    always_ff @(posedge CLK) begin
        if (RST) begin
            size      <= 2'b00;
            sign      <= 1'b0;
            addr      <= 32'h0;
            wdata     <= 32'h0;
            merge     <= 32'h0;
            err       <= 1'b0;
            LSU_RDATA <= 32'h0;
        end else begin
            if (state == IDLE && LSU_REQ) begin
                size  <= LSU_SIZE;
                sign  <= LSU_SIGN;
                addr  <= LSU_ADDR;
                wdata <= LSU_WDATA;
                merge <= LSU_WDATA;
                err   <= misaligned;
            end
            if (state == RD)     LSU_RDATA <= load_val;
            if (state == RMW_RD) merge     <= merged;
        end
    end
endmodule

// File: tb/tb_otter_lsu.sv
// tb_otter_lsu: directed vector bench for otter_lsu with a word memory model
module tb_otter_lsu;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        LSU_REQ = 1'b0, LSU_WE = 1'b0, LSU_SIGN = 1'b0;
    logic [1:0]  LSU_SIZE = 2'b00;
    logic [31:0] LSU_ADDR = 32'h0, LSU_WDATA = 32'h0;
    logic        LSU_READY, LSU_DONE, LSU_ERR, MEM_RDEN2, MEM_WE2;
    logic [31:0] LSU_RDATA, MEM_ADDR2, MEM_DIN2, MEM_DOUT2;
    logic        preload = 1'b1;
    logic [31:0] mem [0:63];
    int          checks = 0, errors = 0;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sign;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic [31:0] exp_din;
        logic [31:0] exp_word;
        logic        exp_err;
        int          exp_cyc;
    } vec_t;

    vec_t tbl [19];

    otter_lsu dut (
        .CLK(CLK), .RST(RST), .LSU_REQ(LSU_REQ), .LSU_WE(LSU_WE), .LSU_SIZE(LSU_SIZE),
        .LSU_SIGN(LSU_SIGN), .LSU_ADDR(LSU_ADDR), .LSU_WDATA(LSU_WDATA),
        .LSU_READY(LSU_READY), .LSU_DONE(LSU_DONE), .LSU_ERR(LSU_ERR), .LSU_RDATA(LSU_RDATA),
        .MEM_RDEN2(MEM_RDEN2), .MEM_WE2(MEM_WE2), .MEM_ADDR2(MEM_ADDR2), .MEM_DIN2(MEM_DIN2),
        .MEM_DOUT2(MEM_DOUT2)
    );

    always #5 CLK = ~CLK;

    assign MEM_DOUT2 = mem[MEM_ADDR2[7:2]];

    // memory model: preload during the first reset, then commit port-2 writes
    always @(posedge CLK) begin
        if (preload) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
            mem[16] <= 32'h80F1_7F22;
        end else if (MEM_WE2) mem[MEM_ADDR2[7:2]] <= MEM_DIN2;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run(input vec_t v, input int n);
        int          done_cyc = -1;
        int          we_n = 0, rd_n = 0;
        logic [31:0] din = 32'h0, rdata = 32'h0;
        logic        err = 1'b0;
        logic        sub_store = v.we && v.size != 2'b10;
        chk($sformatf("v%0d ready", n), 32'(LSU_READY), 32'd1);
        LSU_REQ = 1'b1; LSU_WE = v.we; LSU_SIZE = v.size; LSU_SIGN = v.sign;
        LSU_ADDR = v.addr; LSU_WDATA = v.wdata;
        for (int c = 1; c <= 8; c++) begin
            @(posedge CLK); #1;
            if (c == 1) LSU_REQ = 1'b0;
            if (MEM_WE2) begin we_n++; din = MEM_DIN2; end
            if (MEM_RDEN2) rd_n++;
            if ((MEM_WE2 || MEM_RDEN2) && MEM_ADDR2 !== {v.addr[31:2], 2'b00})
                chk($sformatf("v%0d addr2", n), MEM_ADDR2, {v.addr[31:2], 2'b00});
            if (LSU_DONE && done_cyc < 0) begin
                done_cyc = c; err = LSU_ERR; rdata = LSU_RDATA;
            end
        end
        chk($sformatf("v%0d done_cyc", n), 32'(done_cyc), 32'(v.exp_cyc));
        chk($sformatf("v%0d err", n), 32'(err), 32'(v.exp_err));
        chk($sformatf("v%0d rdata", n), rdata, v.exp_rdata);
        chk($sformatf("v%0d we_cycles", n), 32'(we_n), (v.we && !v.exp_err) ? 32'd1 : 32'd0);
        chk($sformatf("v%0d rd_cycles", n), 32'(rd_n), (!v.exp_err && (!v.we || sub_store)) ? 32'd1 : 32'd0);
        if (v.we && !v.exp_err) chk($sformatf("v%0d din2", n), din, v.exp_din);
        chk($sformatf("v%0d mem_word", n), mem[v.addr[7:2]], v.exp_word);
        chk($sformatf("v%0d idle_after", n), 32'(LSU_READY), 32'd1);
    endtask

    initial begin
        int acc = 0, rd = 0, dn = 0, we_seen = 0;
        //          we    size   sg    addr    wdata          rdata          din            word           err cyc
        tbl[0]  = '{1'b0, 2'b00, 1'b1, 32'h41, 32'h0,         32'h0000_007F, 32'h0,         32'h80F1_7F22, 1'b0, 2};
        tbl[1]  = '{1'b0, 2'b00, 1'b1, 32'h42, 32'h0,         32'hFFFF_FFF1, 32'h0,         32'h80F1_7F22, 1'b0, 2};
        tbl[2]  = '{1'b0, 2'b00, 1'b0, 32'h43, 32'h0,         32'h0000_0080, 32'h0,         32'h80F1_7F22, 1'b0, 2};
        tbl[3]  = '{1'b0, 2'b01, 1'b1, 32'h42, 32'h0,         32'hFFFF_80F1, 32'h0,         32'h80F1_7F22, 1'b0, 2};
        tbl[4]  = '{1'b0, 2'b10, 1'b0, 32'h40, 32'h0,         32'h80F1_7F22, 32'h0,         32'h80F1_7F22, 1'b0, 2};
        tbl[5]  = '{1'b1, 2'b00, 1'b0, 32'h41, 32'h1234_5699, 32'h80F1_7F22, 32'h80F1_9922, 32'h80F1_9922, 1'b0, 3};
        tbl[6]  = '{1'b0, 2'b10, 1'b0, 32'h40, 32'h0,         32'h80F1_9922, 32'h0,         32'h80F1_9922, 1'b0, 2};
        tbl[7]  = '{1'b1, 2'b10, 1'b0, 32'h40, 32'h80F1_7F22, 32'h80F1_9922, 32'h80F1_7F22, 32'h80F1_7F22, 1'b0, 2};
        tbl[8]  = '{1'b1, 2'b01, 1'b0, 32'h42, 32'hDEAD_BEEF, 32'h80F1_9922, 32'hBEEF_7F22, 32'hBEEF_7F22, 1'b0, 3};
        tbl[9]  = '{1'b0, 2'b10, 1'b0, 32'h40, 32'h0,         32'hBEEF_7F22, 32'h0,         32'hBEEF_7F22, 1'b0, 2};
        tbl[10] = '{1'b1, 2'b10, 1'b0, 32'h44, 32'hCAFE_F00D, 32'hBEEF_7F22, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 2};
        tbl[11] = '{1'b0, 2'b01, 1'b0, 32'h46, 32'h0,         32'h0000_CAFE, 32'h0,         32'hCAFE_F00D, 1'b0, 2};
        tbl[12] = '{1'b0, 2'b00, 1'b1, 32'h45, 32'h0,         32'hFFFF_FFF0, 32'h0,         32'hCAFE_F00D, 1'b0, 2};
        tbl[13] = '{1'b0, 2'b10, 1'b0, 32'h42, 32'h0,         32'hFFFF_FFF0, 32'h0,         32'hBEEF_7F22, 1'b1, 1};
        tbl[14] = '{1'b1, 2'b01, 1'b0, 32'h43, 32'h0,         32'hFFFF_FFF0, 32'h0,         32'hBEEF_7F22, 1'b1, 1};
        tbl[15] = '{1'b1, 2'b11, 1'b0, 32'h40, 32'h0,         32'hFFFF_FFF0, 32'h0,         32'hBEEF_7F22, 1'b1, 1};
        tbl[16] = '{1'b0, 2'b01, 1'b1, 32'h41, 32'h0,         32'hFFFF_FFF0, 32'h0,         32'hBEEF_7F22, 1'b1, 1};
        tbl[17] = '{1'b1, 2'b00, 1'b0, 32'h43, 32'h0000_00AA, 32'hFFFF_FFF0, 32'hAAEF_7F22, 32'hAAEF_7F22, 1'b0, 3};
        tbl[18] = '{1'b0, 2'b00, 1'b1, 32'h43, 32'h0,         32'hFFFF_FFAA, 32'h0,         32'hAAEF_7F22, 1'b0, 2};

        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        preload = 1'b0;
        chk("rst ready", 32'(LSU_READY), 32'd1);
        chk("rst done", 32'(LSU_DONE), 32'd0);
        chk("rst err", 32'(LSU_ERR), 32'd0);
        chk("rst rden2", 32'(MEM_RDEN2), 32'd0);
        chk("rst we2", 32'(MEM_WE2), 32'd0);
        chk("rst addr2", MEM_ADDR2, 32'h0);
        chk("rst din2", MEM_DIN2, 32'h0);
        chk("rst rdata", LSU_RDATA, 32'h0);

        for (int i = 0; i < 19; i++) run(tbl[i], i);

        // request held high: one access per accept, nothing queued
        LSU_REQ = 1'b1; LSU_WE = 1'b0; LSU_SIZE = 2'b10; LSU_SIGN = 1'b0; LSU_ADDR = 32'h44;
        for (int c = 0; c < 9; c++) begin
            if (LSU_READY && LSU_REQ) acc++;
            if (MEM_RDEN2) rd++;
            if (LSU_DONE) dn++;
            @(posedge CLK); #1;
        end
        LSU_REQ = 1'b0;
        chk("hold accepts", 32'(acc), 32'd3);
        chk("hold reads", 32'(rd), 32'd3);
        chk("hold dones", 32'(dn), 32'd3);
        chk("hold rdata", LSU_RDATA, 32'hCAFE_F00D);
        @(posedge CLK); #1;
        chk("hold idle", 32'(LSU_READY), 32'd1);

        // reset during the read half of a byte store
        LSU_REQ = 1'b1; LSU_WE = 1'b1; LSU_SIZE = 2'b00; LSU_ADDR = 32'h40; LSU_WDATA = 32'h55;
        @(posedge CLK); #1;
        LSU_REQ = 1'b0;
        chk("rmw rden2", 32'(MEM_RDEN2), 32'd1);
        RST = 1'b1;
        dn = 0;
        if (MEM_WE2) we_seen++;
        @(posedge CLK); #1;
        RST = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (MEM_WE2) we_seen++;
            if (LSU_DONE) dn++;
            @(posedge CLK); #1;
        end
        chk("rstmid we2", 32'(we_seen), 32'd0);
        chk("rstmid done", 32'(dn), 32'd0);
        chk("rstmid ready", 32'(LSU_READY), 32'd1);
        chk("rstmid rdata", LSU_RDATA, 32'h0);
        chk("rstmid mem", mem[16], 32'hAAEF_7F22);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/otter_lsu.md
# otter_lsu

Load/store unit sitting directly upstream of the OTTER data memory port (port 2). Accepts byte/halfword/word load and store requests from the execute stage and issues word-aligned accesses on the memory's port-2 signals. Extracts and sign/zero-extends load data and performs read-modify-write for sub-word stores, because the memory commits only full 32-bit words. Detects misaligned accesses and reports them without touching memory.

## Interface
- No parameters; 32-bit addresses and data, 4-byte words, little-endian byte lanes.

Ports:
- CLK  in  1  system clock; all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- LSU_REQ  in  1  request valid; accepted only when LSU_READY=1
- LSU_WE  in  1  1 = store, 0 = load
- LSU_SIZE  in  2  00 byte, 01 half, 10 word, 11 illegal
- LSU_SIGN  in  1  loads: 1 sign-extend (LB/LH), 0 zero-extend (LBU/LHU); ignored for stores and words
- LSU_ADDR  in  32  byte address
- LSU_WDATA  in  32  store data, right-justified (byte in [7:0], half in [15:0])
- LSU_READY  out  1  1 in IDLE only
- LSU_DONE  out  1  one-cycle completion pulse
- LSU_ERR  out  1  high with LSU_DONE when the request was misaligned/illegal
- LSU_RDATA  out  32  extended load result; registered, holds until next successful load
- MEM_RDEN2  out  1  memory read enable
- MEM_WE2  out  1  memory write enable
- MEM_ADDR2  out  32  word-aligned address ({addr[31:2],2'b00})
- MEM_DIN2  out  32  full word to write
- MEM_DOUT2  in  32  memory read data, combinational, valid in the same cycle as MEM_ADDR2/MEM_RDEN2

## Operation
- States: IDLE, RD, RMW_RD, WR, RESP.
- IDLE: READY=1. On LSU_REQ, latch WE, SIZE, SIGN, ADDR, WDATA. Misaligned = (SIZE=01 & addr[0]) | (SIZE=10 & addr[1:0]≠0) | SIZE=11 -> RESP with err flag. Otherwise load -> RD; word store -> WR with merge reg = WDATA; byte/half store -> RMW_RD.
- RD: RDEN2=1, ADDR2=aligned addr. Extract lane from MEM_DOUT2 (byte lane = addr[1:0], half = addr[1] ? [31:16] : [15:0]), extend per SIGN, register into LSU_RDATA -> RESP.
- RMW_RD: RDEN2=1; register merge = MEM_DOUT2 with addressed lane(s) replaced by WDATA[7:0] / WDATA[15:0] -> WR.
- WR: WE2=1, DIN2=merge -> RESP.
- RESP: DONE=1, ERR=err flag -> IDLE.
- Outside RD/RMW_RD/WR: RDEN2=0, WE2=0, ADDR2=0, DIN2=0.
- LSU_REQ while READY=0 is ignored (no queuing). Caller must re-present after DONE.
- Stores and errored requests leave LSU_RDATA unchanged.
- Exactly one WE2 cycle per successful store; zero memory accesses for errored requests.

## Timing
- Reset (RST high at edge): state=IDLE, LSU_RDATA=0, err flag=0, merge=0. Outputs after reset: READY=1, DONE=0, ERR=0, RDEN2=0, WE2=0, ADDR2=0, DIN2=0.
- MEM_WE2 is gated by !RST, so a write in flight does not commit in a cycle where RST is high. Reset mid-operation abandons the request without a DONE.
- Latency, counting the accept cycle as 0: load DONE at cycle 2; word store WE2 at cycle 1, DONE at cycle 2; sub-word store RD at 1, WE2 at 2, DONE at 3; misaligned DONE+ERR at cycle 1.
- LSU_RDATA is valid from the DONE cycle onward.
- Next request can be accepted the cycle after DONE.

## Test plan
- Preload word 0x40 = 0x80F17F22. Issue LB 0x41, LB 0x42 signed, LBU 0x43, LH 0x42 signed, LW 0x40 -> LSU_RDATA 0x0000007F, 0xFFFFFFF1, 0x00000080, 0xFFFF80F1, 0x80F17F22; each DONE exactly 2 cycles after accept.
- SB 0x41, WDATA 0x12345699 -> one WE2 cycle with DIN2=0x80F19922, DONE at cycle 3; a following LW 0x40 returns 0x80F19922.
- SH 0x42, WDATA 0xDEADBEEF on 0x80F17F22 -> word becomes 0xBEEF7F22. SW 0x44, 0xCAFEF00D -> WE2 at cycle 1, DONE at cycle 2.
- LW 0x42, SH 0x43, SIZE=11 -> DONE+ERR at cycle 1; RDEN2/WE2 never high; memory and LSU_RDATA unchanged.
- SB issued, then RST high during the RMW_RD cycle -> no WE2 ever, READY=1 after reset, memory unchanged, LSU_RDATA=0.
- LSU_REQ held high continuously with a LW -> one access per accept; requests presented during RD/RESP are not executed.
